// File: rtl/cic_decimator.sv
// cic_decimator: 3-stage CIC decimating filter, decimation by 32, differential delay 1.
//   Integrators run at the input rate and the combs run at the output rate.
//   Each clock takes one signed DIN_W sample. Every R clocks the block registers
//   one signed DOUT_W result, which is the full-precision value truncated.
// Ports:
//   cic_clk   in   clock, also the input sample rate
//   cic_rstn  in   asynchronous active-low reset, clears all filter state
//   cic_din   in   signed input sample, taken on every rising edge
//   cic_dout  out  signed decimated output, registered, held between updates
module cic_decimator #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 16,
  parameter int R      = 32,
  parameter int N      = 3,
  parameter int CNT_W  = 5,
  parameter int ACC_W  = DIN_W + N * CNT_W
) (
  input  logic                     cic_clk,
  input  logic                     cic_rstn,
  input  logic signed [DIN_W-1:0]  cic_din,
  output logic signed [DOUT_W-1:0] cic_dout
);

  localparam int SH = ACC_W - DOUT_W;  // LSBs dropped by output truncation

  logic [CNT_W-1:0]           samp_cnt, samp_cnt_d;
  logic                       strobe;
  logic [N-1:0][ACC_W-1:0]    integ_q, integ_d;
  logic [N-1:0][ACC_W-1:0]    dly_q;    // comb delay elements d1..dN
  logic [N-1:0][ACC_W-1:0]    comb_y;   // c0, y1 .. y(N-1); each feeds its delay
  logic                       borrow;
  logic [DOUT_W-1:0]          dout_d;

  assign strobe = (samp_cnt == CNT_W'(R - 1));

  always_comb begin
    logic [ACC_W-1:0] y;
    samp_cnt_d = samp_cnt + 1'b1;
    // Integrator arithmetic is modular. Wrap is harmless because the combs
    // difference the same wrapped values.
    integ_d[0] = integ_q[0] + {{(ACC_W-DIN_W){cic_din[DIN_W-1]}}, cic_din};
    for (int i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
    y = integ_q[N-1];
    comb_y[0] = y;
    for (int j = 1; j < N; j++) begin
      y = y - dly_q[j-1];
      comb_y[j] = y;
    end
    // The last comb difference is computed only on the kept MSBs.
    // The borrow from the dropped LSBs keeps the result identical to
    // floor((a - b) / 2^SH), so no full-width result is ever formed.
    borrow = comb_y[N-1][SH-1:0] < dly_q[N-1][SH-1:0];
    dout_d = comb_y[N-1][ACC_W-1:SH] - dly_q[N-1][ACC_W-1:SH] - DOUT_W'(borrow);
  end

  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      samp_cnt <= '0;
      integ_q  <= '0;
      dly_q    <= '0;
      cic_dout <= '0;
    end else begin
      samp_cnt <= samp_cnt_d;
      integ_q  <= integ_d;
      if (strobe) begin
        dly_q    <= comb_y;
        cic_dout <= dout_d;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed checks of the CIC decimator.
// Expected outputs are hand-derived from the CIC impulse response h[k]:
//   the coefficients of (1+z+..+z^31)^3, which has 94 taps summing to 32768.
// The first sample taken after reset release arrives on edge 1.
// An output produced on strobe edge t sees h[t-3-n] from the input taken on edge n.
module tb_cic_decimator;
  logic               cic_clk = 1'b0;
  logic               cic_rstn;
  logic signed [7:0]  cic_din;
  logic signed [15:0] cic_dout;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 cic_clk = ~cic_clk;

  cic_decimator dut (
    .cic_clk  (cic_clk),
    .cic_rstn (cic_rstn),
    .cic_din  (cic_din),
    .cic_dout (cic_dout)
  );

  task automatic do_reset();
    cic_rstn = 1'b0;
    cic_din  = 8'sd0;
    repeat (3) @(posedge cic_clk);
    #1 cic_rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic step(input logic signed [7:0] v);
    cic_din = v;
    @(posedge cic_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic signed [7:0] v;
    cic_rstn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cic_din = 8'($urandom);
      @(posedge cic_clk);
      #1;
      total++;
      if (cic_dout !== 16'sd0) begin bad++; $display("FAIL reset_dout: got %0d want 0", cic_dout); end
      total++;
      if (dut.samp_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dut.samp_cnt); end
    end
    do_reset();
    v = 8'sd50;
    for (int i = 1; i <= 70; i++) begin
      step(v);
      if (cyc == 64) begin
        total++;
        if (cic_dout !== 16'sd10244) begin bad++; $display("FAIL pre_reset_64: got %0d want 10244", cic_dout); end
      end
    end
    // Assert reset between clock edges. The output must clear without a clock.
    #3 cic_rstn = 1'b0;
    #1;
    total++;
    if (cic_dout !== 16'sd0) begin bad++; $display("FAIL midrun_dout: got %0d want 0", cic_dout); end
    total++;
    if (dut.samp_cnt !== 5'd0) begin bad++; $display("FAIL midrun_cnt: got %0d want 0", dut.samp_cnt); end
    // After restart, the response must match a fresh filter with no stale state.
    do_reset();
    v = -8'sd100;
    for (int i = 1; i <= 64; i++) begin
      step(v);
      if (cyc == 31) begin
        total++;
        if (cic_dout !== 16'sd0) begin bad++; $display("FAIL restart_31: got %0d want 0", cic_dout); end
      end
      if (cyc == 32) begin
        total++;
        if (cic_dout !== -16'sd3512) begin bad++; $display("FAIL restart_32: got %0d want -3512", cic_dout); end
      end
      if (cyc == 64) begin
        total++;
        if (cic_dout !== -16'sd20490) begin bad++; $display("FAIL restart_64: got %0d want -20490", cic_dout); end
      end
    end
  endtask

  task automatic test_zero();
    do_reset();
    for (int i = 1; i <= 400; i++) begin
      step(8'sd0);
      total++;
      if (cic_dout !== 16'sd0) begin bad++; $display("FAIL zero_in cyc %0d: got %0d want 0", cyc, cic_dout); end
    end
  endtask

  // Input is 100 zeros, then 300 samples of 100, then zeros again.
  // This also checks that the output holds between strobes and that samp_cnt tracks the bench's own counter.
  task automatic test_step();
    int prev;
    int expv;
    logic signed [7:0] v;
    do_reset();
    prev = 0;
    for (int i = 1; i <= 560; i++) begin
      v = (i > 100 && i <= 400) ? 8'sd100 : 8'sd0;
      step(v);
      total++;
      if (dut.samp_cnt !== 5'(cyc % 32)) begin
        bad++; $display("FAIL step_cnt cyc %0d: got %0d want %0d", cyc, dut.samp_cnt, cyc % 32);
      end
      if (cyc % 32 != 0) begin
        total++;
        if (int'(cic_dout) != prev) begin bad++; $display("FAIL step_hold cyc %0d: got %0d want %0d", cyc, cic_dout, prev); end
      end else begin
        total++;
        if ((cyc <= 400 && int'(cic_dout) < prev) || (cyc > 400 && int'(cic_dout) > prev)) begin
          bad++; $display("FAIL step_monotonic cyc %0d: got %0d prev %0d", cyc, cic_dout, prev);
        end
        expv = -1;
        case (cyc)
          96:  expv = 0;
          128: expv = 2285;
          160: expv = 18542;
          192: expv = 25572;
          416: expv = 25244;
          448: expv = 13998;
          480: expv = 757;
          512: expv = 0;
          544: expv = 0;
          default: if (cyc >= 224 && cyc <= 384) expv = 25600;
        endcase
        if (expv >= 0) begin
          total++;
          if (int'(cic_dout) != expv) begin bad++; $display("FAIL step_value cyc %0d: got %0d want %0d", cyc, cic_dout, expv); end
        end
      end
      prev = int'(cic_dout);
    end
  endtask

  task automatic test_const(input logic signed [7:0] v, input logic signed [15:0] expv, input int ncyc);
    do_reset();
    for (int i = 1; i <= ncyc; i++) begin
      step(v);
      if (cyc % 32 == 0 && cyc >= 128) begin
        total++;
        if (cic_dout !== expv) begin bad++; $display("FAIL const_%0d cyc %0d: got %0d want %0d", v, cyc, cic_dout, expv); end
      end
    end
  endtask

  // A single sample on edge 45 lands on taps h[16], h[48] and h[80].
  // These are 153, 766 and 105, each scaled by the impulse amplitude and then floored.
  task automatic test_impulse(input logic signed [7:0] amp, input int e64, input int e96, input int e128);
    int sum;
    int expv;
    do_reset();
    sum = 0;
    for (int i = 1; i <= 224; i++) begin
      step((i == 45) ? amp : 8'sd0);
      if (cyc % 32 == 0) begin
        sum += int'(cic_dout);
        case (cyc)
          64:  expv = e64;
          96:  expv = e96;
          128: expv = e128;
          default: expv = 0;
        endcase
        total++;
        if (int'(cic_dout) != expv) begin bad++; $display("FAIL impulse_%0d cyc %0d: got %0d want %0d", amp, cyc, cic_dout, expv); end
      end
    end
    total++;
    if (sum != e64 + e96 + e128) begin bad++; $display("FAIL impulse_sum_%0d: got %0d want %0d", amp, sum, e64 + e96 + e128); end
  endtask

  // With busy input, the output may change only on edges where samp_cnt was 31.
  task automatic test_rate();
    int prev;
    int changes;
    do_reset();
    prev = 0;
    changes = 0;
    for (int i = 1; i <= 320; i++) begin
      step(8'(i * 37 + 11));
      total++;
      if (dut.samp_cnt !== 5'(cyc % 32)) begin
        bad++; $display("FAIL rate_cnt cyc %0d: got %0d want %0d", cyc, dut.samp_cnt, cyc % 32);
      end
      if (cyc % 32 != 0) begin
        total++;
        if (int'(cic_dout) != prev) begin bad++; $display("FAIL rate_hold cyc %0d: got %0d want %0d", cyc, cic_dout, prev); end
      end else if (int'(cic_dout) != prev) begin
        changes++;
      end
      prev = int'(cic_dout);
    end
    total++;
    if (changes < 5) begin bad++; $display("FAIL rate_updates: got %0d want >=5", changes); end
  endtask

  initial begin
    cic_rstn = 1'b0;
    cic_din  = 8'sd0;
    test_reset();
    test_zero();
    test_step();
    test_const(-8'sd100, -16'sd25600, 640);
    test_const(-8'sd128, -16'sd32768, 640);
    test_const(8'sd127, 16'sd32512, 4096);
    test_impulse(8'sd100, 119, 598, 82);
    test_impulse(-8'sd100, -120, -599, -83);
    test_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
